// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared types for the bit-serial subtractor.
//   state_t : sequencing states of the serial_subtractor control FSM
//             IDLE - waiting for operands (in_ready high)
//             RUN  - one result bit produced per clock, LSB first
//             DONE - result held until the consumer takes it
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor cell computing a - b - bin.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH, computed
// LSB first through a single full_subtractor cell and a borrow flop. Operands
// and results move over valid/ready handshakes.
// Parameters:
//   WIDTH      operand/result width (>= 2)
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   producer offers a/b/bin
//   in_ready   high in IDLE only
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  high in DONE; diff/bout/zero valid
//   out_ready  consumer accepts the result
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       final borrow (a < b + bin)
//   zero       diff == 0
// Latency: accept at edge N, out_valid high after edge N+WIDTH.
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               br_q,     br_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   diff_q,   diff_d;
  logic               bout_q,   bout_d;
  logic               zero_q,   zero_d;

  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    // NOTE: every signal assigned here gets its hold value first, so no
    // path through the case statement can leave it unassigned (no latch).
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // Result enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
        res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};
        br_d     = cell_bout;
        if (cnt_q == CNT_LAST) begin
          // Publish into separate output registers so diff only changes
          // when a complete result is available.
          cnt_d   = '0;
          diff_d  = res_sr_d;
          bout_d  = cell_bout;
          zero_d  = (res_sr_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule : serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing a − b − bin, LSB first, one bit per clock, through a single full-subtractor cell and a borrow flop. It is the inverse arithmetic companion to the full_adder cell, for area-constrained datapaths where latency is acceptable. Operands enter and results leave over valid/ready handshakes, so the block drops between a producer and a consumer without glue logic.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  producer presents a, b, bin.
- in_ready  output  1  block can accept operands (IDLE only).
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout/zero hold a valid result.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
- zero  output  1  1 iff diff == 0.

## Operation
- FSM states: IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, load shift registers with a and b, set borrow flop to bin, clear bit counter, go to RUN.
- RUN: each cycle, cell inputs are a_sr[0], b_sr[0], borrow. d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br). Shift a_sr and b_sr right by one. Shift d into the result register at the MSB. Increment the counter.
- RUN exit: on the cycle where counter == WIDTH−1, go to DONE. bout takes the final br_next. zero is computed from the completed result.
- DONE: diff, bout, and zero are held stable while out_ready = 0. On out_ready = 1, go to IDLE. The next operand is not accepted in that same cycle.
- in_valid outside IDLE is ignored; operands are not captured.
- Counter width: $clog2(WIDTH). Counter never exceeds WIDTH−1.
- Reset values, applied at any state including mid-RUN: state = IDLE (so in_ready = 1 on the first cycle after reset), out_valid = 0, diff = 0, bout = 0, zero = 0, borrow flop = 0, counter = 0. An aborted operation never produces a result.

## Timing
- Accept at edge N: RUN occupies the WIDTH cycles that follow. out_valid rises after edge N+WIDTH.
- Minimum throughput: one result per WIDTH+2 cycles, which includes the handshake cycle in DONE and the return to IDLE.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.
- out_ready held high through DONE: out_valid is high for exactly one cycle.
- Back-pressure: out_valid stays high, and outputs stay unchanged, for every cycle out_ready is low.

## Structure
- Package serial_sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t.
  - Borrow-equation helper constants, if any.
- Sub-module full_subtractor: purely combinational.
  - Ports a, b, bin, d, bout, mirroring the full_adder port style.
  - Instantiated once in serial_subtractor.
- Top holds the FSM, the a/b shift registers, the result shift register, the counter, and the borrow flop.

## Test plan
- WIDTH = 8, a = 0x5A, b = 0x3C, bin = 0, out_ready = 1 → diff = 0x1E, bout = 0, zero = 0; out_valid exactly 8 cycles after the accept edge, high for one cycle.
- a = 0x00, b = 0x01, bin = 0 → diff = 0xFF, bout = 1, zero = 0.
- a = 0x80, b = 0x80, bin = 0 → diff = 0x00, bout = 0, zero = 1. Repeat with bin = 1 → diff = 0xFF, bout = 1.
- a = 0x10, b = 0x01, out_ready held low 5 cycles after out_valid → out_valid and diff = 0x0F stable throughout. Return to IDLE one cycle after out_ready = 1. in_valid pulsed during RUN/DONE is not captured.
- rst_n low for one cycle after 3 RUN cycles → next cycle state IDLE, in_ready = 1, out_valid = 0, diff = 0. A new a = 0x03, b = 0x01 then yields diff = 0x02.
- Random sweep, WIDTH ∈ {2, 8, 16}, 1000 operand pairs, random out_ready → diff/bout match a − b − bin reference model.
